// File: rtl/edge_event_counter_pkg.sv
// Shared state encoding, default widths and saturation-limit helper
// for edge_event_counter.
package edge_event_counter_pkg;

    localparam int CNT_W_DEF = 8;
    localparam int WIN_W_DEF = 16;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t COUNT = 2'd1;
    localparam state_t HOLD  = 2'd2;

    function automatic longint unsigned sat_limit(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction

endpackage

// File: rtl/edge_event_counter_xdet.sv
// Mealy 1-bit transition detector; the first bit after init only
// sets the reference and never produces a pulse.
module edge_xdet (
    input  logic Clk,
    input  logic Clr_n,
    input  logic init,
    input  logic raw,
    output logic pulse
);

    logic prev;
    logic armed;

    always_ff @(posedge Clk) begin
        if (!Clr_n) begin
            prev  <= 1'b0;
            armed <= 1'b0;
        end else if (init) begin
            armed <= 1'b0;
        end else begin
            prev  <= raw;
            armed <= 1'b1;
        end
    end

    assign pulse = armed && (raw != prev);

endmodule

// File: rtl/edge_event_counter.sv
// Windowed, saturating event counter with valid/ready result.
// Define EDGE_DETECT_EN to count transitions of a raw serial bit.
module edge_event_counter
    import edge_event_counter_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int WIN_W = WIN_W_DEF
) (
    input  logic             Clk,
    input  logic             Clr_n,
    input  logic             Start,
    input  logic [WIN_W-1:0] Win_len,
    input  logic             Edge,
    output logic [CNT_W-1:0] Count,
    output logic             Valid,
    input  logic             Ready,
    output logic             Busy,
    output logic             Sat
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(sat_limit(CNT_W));

    state_t           state;
    state_t           state_nx;
    logic [WIN_W-1:0] rem;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic             sat;
    logic             start_ok;
    logic             pulse;

    assign start_ok = (state == IDLE) && Start;

`ifdef EDGE_DETECT_EN
    edge_xdet u_xdet (
        .Clk   (Clk),
        .Clr_n (Clr_n),
        .init  (start_ok),
        .raw   (Edge),
        .pulse (pulse)
    );
`else
    assign pulse = Edge;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (Start)
                    state_nx = (Win_len == '0) ? HOLD : COUNT;
            end
            COUNT: begin
                if (rem == WIN_W'(1))
                    state_nx = HOLD;
            end
            HOLD: begin
                if (Ready)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Holds at LIMIT instead of wrapping
    assign cnt_nx = (cnt == LIMIT) ? cnt : cnt + 1'b1;

    always_ff @(posedge Clk) begin
        if (!Clr_n) begin
            state <= IDLE;
            rem   <= '0;
            cnt   <= '0;
            sat   <= 1'b0;
        end else begin
            state <= state_nx;
            if (start_ok) begin
                rem <= Win_len;
                cnt <= '0;
                sat <= 1'b0;
            end else if (state == COUNT) begin
                rem <= rem - 1'b1;
                if (pulse) begin
                    cnt <= cnt_nx;
                    if (cnt_nx == LIMIT)
                        sat <= 1'b1;
                end
            end
        end
    end

    assign Count = cnt;
    assign Valid = (state == HOLD);
    assign Busy  = (state != IDLE);
    assign Sat   = sat;

endmodule
